tip_hello_clock_divgen: RTL and testbench

TIP_HELLO_CLOCK_DIVGEN -- requirements
Module: tip_hello_clock_divgen

---
 rtl/tip_hello_clock_divgen.sv | 135 +++++++++++++
 tb/tb_tip_hello_clock_divgen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tip_hello_clock_divgen.sv
// Multi-channel programmable clock divider with period-aligned divisor updates and a lock gate.
// Define TIP_HELLO_CLOCK_LOCK_WAIT_EN to hold all channels off for LOCK_CYCLES after reset.
module tip_hello_clock_divgen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_WIDTH   = 8,
  parameter int DIV_INIT    = 2,
  parameter int LOCK_CYCLES = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 external_clk,
  input  logic                 external_rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [NUM_CH-1:0]    ch_enable,
  output logic [NUM_CH-1:0]    clk_div,
  output logic [NUM_CH-1:0]    clk_tick,
  output logic                 locked
);

  logic [NUM_CH-1:0] pending;

  // Out-of-range channel indices fall through to ready so such writes are silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] shadow_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH:0]   half;
    logic                 pend_q;
    logic                 div_r;
    logic                 tick_r;
    logic                 run;
    logic                 wrap;
    logic                 wr_en;

    assign half  = ({1'b0, div_q} + (DIV_WIDTH+1)'(1)) >> 1;
    assign run   = locked && ch_enable[g] && (div_q != '0);
    assign wrap  = (cnt_q == div_q - DIV_WIDTH'(1));
    assign wr_en = cfg_valid && !pend_q && (cfg_ch == CH_W'(g));

    assign pending[g]  = pend_q;
    assign clk_div[g]  = div_r;
    assign clk_tick[g] = tick_r;

    // A new divisor only lands on a period boundary while running, so no period is ever cut short.
    always_ff @(posedge external_clk or posedge external_rst) begin
      if (external_rst) begin
        div_q    <= DIV_WIDTH'(DIV_INIT);
        shadow_q <= DIV_WIDTH'(DIV_INIT);
        pend_q   <= 1'b0;
        cnt_q    <= '0;
        div_r    <= 1'b0;
        tick_r   <= 1'b0;
      end else begin
        if (wr_en) begin
          shadow_q <= cfg_div;
          pend_q   <= 1'b1;
        end else if (pend_q && (!run || wrap)) begin
          div_q  <= shadow_q;
          pend_q <= 1'b0;
        end

        if (run) begin
          tick_r <= (cnt_q == '0);
          div_r  <= ({1'b0, cnt_q} < half);
          cnt_q  <= wrap ? '0 : cnt_q + DIV_WIDTH'(1);
        end else begin
          tick_r <= 1'b0;
          div_r  <= 1'b0;
          cnt_q  <= '0;
        end
      end
    end
  end

  // Empty marker block that only elaborates for out-of-range parameters.
  if (NUM_CH < 1 || NUM_CH > 8 || LOCK_CYCLES < 1) begin : g_bad_params
  end

`ifdef TIP_HELLO_CLOCK_LOCK_WAIT_EN
  localparam int LK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    LK_WAIT,
    LK_COUNT,
    LK_LOCKED
  } lock_state_t;

  lock_state_t     lock_state;
  logic [LK_W-1:0] lock_cnt;

  // Once LOCKED the gate stays open until the next reset.
  always_ff @(posedge external_clk or posedge external_rst) begin
    if (external_rst) begin
      lock_state <= LK_WAIT;
      lock_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      case (lock_state)
        LK_WAIT: begin
          lock_state <= LK_COUNT;
          lock_cnt   <= '0;
        end
        LK_COUNT: begin
          if (lock_cnt == LK_W'(LOCK_CYCLES - 1)) begin
            lock_state <= LK_LOCKED;
            locked     <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + LK_W'(1);
          end
        end
        LK_LOCKED: locked <= 1'b1;
        default: begin
          lock_state <= LK_WAIT;
          locked     <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge external_clk or posedge external_rst) begin
    if (external_rst) locked <= 1'b0;
    else              locked <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tip_hello_clock_divgen.sv
// Directed self-checking bench for tip_hello_clock_divgen (NUM_CH=3, DIV_INIT=2, LOCK_CYCLES=16).
module tb_tip_hello_clock_divgen;

  localparam int NUM_CH      = 3;
  localparam int DIV_WIDTH   = 8;
  localparam int DIV_INIT    = 2;
  localparam int LOCK_CYCLES = 16;
`ifdef TIP_HELLO_CLOCK_LOCK_WAIT_EN
  localparam int LOCK_LAT = 17;
`else
  localparam int LOCK_LAT = 1;
`endif

  logic                 external_clk = 1'b0;
  logic                 external_rst = 1'b1;
  logic                 cfg_valid    = 1'b0;
  logic                 cfg_ready;
  logic [1:0]           cfg_ch       = 2'd0;
  logic [DIV_WIDTH-1:0] cfg_div      = '0;
  logic [NUM_CH-1:0]    ch_enable    = 3'b111;
  logic [NUM_CH-1:0]    clk_div;
  logic [NUM_CH-1:0]    clk_tick;
  logic                 locked;

  int n_cmp  = 0;
  int n_fail = 0;

  tip_hello_clock_divgen #(
    .NUM_CH     (NUM_CH),
    .DIV_WIDTH  (DIV_WIDTH),
    .DIV_INIT   (DIV_INIT),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .external_clk(external_clk),
    .external_rst(external_rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .ch_enable   (ch_enable),
    .clk_div     (clk_div),
    .clk_tick    (clk_tick),
    .locked      (locked)
  );

  always #5 external_clk = ~external_clk;

  task automatic tick();
    @(posedge external_clk);
    #1;
  endtask

  // Leaves the channel disabled with the new divisor active and its counter at 0.
  task automatic program_channel(input int ch, input logic [DIV_WIDTH-1:0] d);
    ch_enable[ch] = 1'b0;
    tick();
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = d;
    tick();
    cfg_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    external_rst = 1'b1;
    ch_enable    = 3'b111;
    #3;
    n_cmp++; if (clk_div !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_clk_div: got %b expected 000", clk_div); end
    n_cmp++; if (clk_tick !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_clk_tick: got %b expected 000", clk_tick); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    tick();
    tick();
    external_rst = 1'b0;
  endtask

  task automatic test_lock(input string tag);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL %s locked_at_release: got %b expected 0", tag, locked); end
    for (int k = 1; k <= LOCK_LAT; k++) begin
      tick();
      n_cmp++; if (locked !== (k >= LOCK_LAT)) begin n_fail++; $display("[TB] FAIL %s locked_cycle%0d: got %b expected %b", tag, k, locked, (k >= LOCK_LAT)); end
      n_cmp++; if (clk_tick !== 3'b000) begin n_fail++; $display("[TB] FAIL %s tick_before_lock%0d: got %b expected 000", tag, k, clk_tick); end
    end
    tick();
    n_cmp++; if (clk_tick !== 3'b111) begin n_fail++; $display("[TB] FAIL %s first_tick: got %b expected 111", tag, clk_tick); end
    n_cmp++; if (clk_div !== 3'b111) begin n_fail++; $display("[TB] FAIL %s first_div: got %b expected 111", tag, clk_div); end
  endtask

  task automatic test_patterns();
    logic [DIV_WIDTH-1:0] divs [4] = '{8'd4, 8'd3, 8'd1, 8'd5};
    logic [7:0]           pats [4] = '{8'b0000_0011, 8'b0000_0011, 8'b0000_0001, 8'b0000_0111};
    int ph;
    for (int c = 0; c < 4; c++) begin
      program_channel(0, divs[c]);
      ch_enable[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
        tick();
        ph = k % int'(divs[c]);
        n_cmp++; if (clk_div[0] !== pats[c][ph]) begin n_fail++; $display("[TB] FAIL pattern_div D=%0d k=%0d: got %b expected %b", divs[c], k, clk_div[0], pats[c][ph]); end
        n_cmp++; if (clk_tick[0] !== (ph == 0)) begin n_fail++; $display("[TB] FAIL pattern_tick D=%0d k=%0d: got %b expected %b", divs[c], k, clk_tick[0], (ph == 0)); end
      end
    end
  endtask

  task automatic test_switch();
    logic [7:0] pat6 = 8'b0000_0111;
    int ph;
    program_channel(0, 8'd4);
    ch_enable[0] = 1'b1;
    tick();
    n_cmp++; if ({clk_div[0], clk_tick[0]} !== 2'b11) begin n_fail++; $display("[TB] FAIL switch_start: got %b expected 11", {clk_div[0], clk_tick[0]}); end
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd6;
    tick();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL switch_ready_cnt1: got %b expected 0", cfg_ready); end
    n_cmp++; if ({clk_div[0], clk_tick[0]} !== 2'b10) begin n_fail++; $display("[TB] FAIL switch_old_ph1: got %b expected 10", {clk_div[0], clk_tick[0]}); end
    tick();
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL switch_ready_cnt2: got %b expected 0", cfg_ready); end
    n_cmp++; if ({clk_div[0], clk_tick[0]} !== 2'b00) begin n_fail++; $display("[TB] FAIL switch_old_ph2: got %b expected 00", {clk_div[0], clk_tick[0]}); end
    tick();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL switch_ready_boundary: got %b expected 1", cfg_ready); end
    n_cmp++; if ({clk_div[0], clk_tick[0]} !== 2'b00) begin n_fail++; $display("[TB] FAIL switch_old_ph3: got %b expected 00", {clk_div[0], clk_tick[0]}); end
    for (int k = 0; k < 12; k++) begin
      tick();
      ph = k % 6;
      n_cmp++; if (clk_div[0] !== pat6[ph]) begin n_fail++; $display("[TB] FAIL switch_div6 k=%0d: got %b expected %b", k, clk_div[0], pat6[ph]); end
      n_cmp++; if (clk_tick[0] !== (ph == 0)) begin n_fail++; $display("[TB] FAIL switch_tick6 k=%0d: got %b expected %b", k, clk_tick[0], (ph == 0)); end
    end
  endtask

  task automatic test_backpressure();
    logic t_a;
    logic t_b;
    ch_enable[0] = 1'b0;
    tick();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd2;
    tick();
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_ready_pending: got %b expected 0", cfg_ready); end
    cfg_div = 8'd9;
    tick();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_after_copy: got %b expected 1", cfg_ready); end
    tick();
    tick();
    ch_enable[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (clk_div[0] !== (k % 2 == 0)) begin n_fail++; $display("[TB] FAIL bp_div2 k=%0d: got %b expected %b", k, clk_div[0], (k % 2 == 0)); end
    end
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_div   = 8'd0;
    #1;
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_ready: got %b expected 1", cfg_ready); end
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_ch = 2'(i);
      #1;
      n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_no_pending ch%0d: got %b expected 1", i, cfg_ready); end
    end
    cfg_ch = 2'd0;
    tick();
    t_a = clk_tick[1];
    tick();
    t_b = clk_tick[1];
    n_cmp++; if ((t_a ^ t_b) !== 1'b1) begin n_fail++; $display("[TB] FAIL oob_ch1_running: got ticks %b%b expected exactly one", t_a, t_b); end
    n_cmp++; if (clk_tick[2] !== t_b) begin n_fail++; $display("[TB] FAIL oob_ch2_running: got %b expected %b", clk_tick[2], t_b); end
  endtask

  task automatic test_enable();
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (clk_tick[1] === 1'b0 && clk_div[1] === 1'b0) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL enable_align: got timeout expected low phase of ch1"); end
    ch_enable[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if ({clk_div[1], clk_tick[1]} !== 2'b00) begin n_fail++; $display("[TB] FAIL enable_off k=%0d: got %b expected 00", k, {clk_div[1], clk_tick[1]}); end
    end
    ch_enable[1] = 1'b1;
    tick();
    n_cmp++; if ({clk_div[1], clk_tick[1]} !== 2'b11) begin n_fail++; $display("[TB] FAIL enable_restart: got %b expected 11", {clk_div[1], clk_tick[1]}); end
    tick();
    n_cmp++; if ({clk_div[1], clk_tick[1]} !== 2'b00) begin n_fail++; $display("[TB] FAIL enable_restart_ph1: got %b expected 00", {clk_div[1], clk_tick[1]}); end
    tick();
    n_cmp++; if ({clk_div[1], clk_tick[1]} !== 2'b11) begin n_fail++; $display("[TB] FAIL enable_restart_ph0: got %b expected 11", {clk_div[1], clk_tick[1]}); end
  endtask

  task automatic test_stop();
    bit         found = 1'b0;
    logic [1:0] exp3 [4] = '{2'b11, 2'b10, 2'b00, 2'b11};
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (clk_tick[2] === 1'b0) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_align: got timeout expected low phase of ch2"); end
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 8'd0;
    tick();
    cfg_valid = 1'b0;
    n_cmp++; if ({clk_div[2], clk_tick[2]} !== 2'b11) begin n_fail++; $display("[TB] FAIL stop_last_period: got %b expected 11", {clk_div[2], clk_tick[2]}); end
    tick();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stop_ready: got %b expected 1", cfg_ready); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_cmp++; if ({clk_div[2], clk_tick[2]} !== 2'b00) begin n_fail++; $display("[TB] FAIL stop_stopped k=%0d: got %b expected 00", k, {clk_div[2], clk_tick[2]}); end
    end
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    tick();
    cfg_valid = 1'b0;
    n_cmp++; if ({clk_div[2], clk_tick[2]} !== 2'b00) begin n_fail++; $display("[TB] FAIL restart_accept: got %b expected 00", {clk_div[2], clk_tick[2]}); end
    tick();
    n_cmp++; if ({clk_div[2], clk_tick[2]} !== 2'b00) begin n_fail++; $display("[TB] FAIL restart_copy: got %b expected 00", {clk_div[2], clk_tick[2]}); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if ({clk_div[2], clk_tick[2]} !== exp3[k]) begin n_fail++; $display("[TB] FAIL restart_div3 k=%0d: got %b expected %b", k, {clk_div[2], clk_tick[2]}, exp3[k]); end
    end
  endtask

  task automatic test_reset_midrun();
    ch_enable = 3'b111;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd2;
    cfg_div   = 8'd7;
    tick();
    cfg_valid = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_pending: got %b expected 0", cfg_ready); end
    #2;
    external_rst = 1'b1;
    #1;
    n_cmp++; if (clk_div !== 3'b000) begin n_fail++; $display("[TB] FAIL midrun_clk_div: got %b expected 000", clk_div); end
    n_cmp++; if (clk_tick !== 3'b000) begin n_fail++; $display("[TB] FAIL midrun_clk_tick: got %b expected 000", clk_tick); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL midrun_locked: got %b expected 0", locked); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrun_pending_cleared: got %b expected 1", cfg_ready); end
    tick();
    tick();
    external_rst = 1'b0;
  endtask

  task automatic test_default_divisor();
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (clk_div !== {3{k % 2 == 0}}) begin n_fail++; $display("[TB] FAIL default_div k=%0d: got %b expected %b", k, clk_div, {3{k % 2 == 0}}); end
    end
  endtask

  initial begin
    test_reset();
    test_lock("power_on");
    test_patterns();
    test_switch();
    test_backpressure();
    test_enable();
    test_stop();
    test_reset_midrun();
    test_lock("after_midrun_reset");
    test_default_divisor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
